// File: rtl/cbus_mem_responder_if.sv
// Cached-bus request/response bundle between an initiator (CPU top or
// arbiter) and a memory-style responder.
interface cbus_mem_responder_if;
   logic        valid;
   logic        is_write;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [3:0]  strobe;
   logic [31:0] wdata;
   logic [3:0]  len;     // beats-1
   logic        burst;   // 1 = INCR, 0 = FIXED
   logic        ready;
   logic        last;
   logic [31:0] rdata;

   modport master (
      output valid, is_write, size, addr, strobe, wdata, len, burst,
      input  ready, last, rdata
   );

   modport slave (
      input  valid, is_write, size, addr, strobe, wdata, len, burst,
      output ready, last, rdata
   );
endinterface

// File: rtl/cbus_mem_responder.sv
// Word-addressed cbus memory responder with programmable first-beat latency
// and inter-beat gaps; serves single/burst reads and strobed writes.
//
// state  | meaning
// S_IDLE | no request in flight; a valid request is latched here
// S_WAIT | counting first-beat latency, ready=0
// S_BEAT | one beat per cycle, ready=1
// S_GAP  | idle cycles between beats of one burst, ready=0
module cbus_mem_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int LATENCY     = 2,
   parameter int BEAT_GAP    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   cbus_mem_responder_if.slave  cbus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
   localparam int GW = (BEAT_GAP > 1) ? $clog2(BEAT_GAP + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_BEAT = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]    state_q,    state_d;
   logic          is_write_q, is_write_d;
   logic [AW-1:0] base_idx_q, base_idx_d;
   logic [3:0]    len_q,      len_d;
   logic          burst_q,    burst_d;
   logic [3:0]    beat_cnt_q, beat_cnt_d;
   logic [LW-1:0] lat_cnt_q,  lat_cnt_d;
   logic [GW-1:0] gap_cnt_q,  gap_cnt_d;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic [AW-1:0] cur_idx;
   logic [31:0]   mem_rd_word;
   logic [31:0]   mem_wr_data;
   logic          mem_wr_en;
   logic          in_beat;
   logic          unused_req_bits;

   // size only matters through strobe; address bits above the array alias.
   assign unused_req_bits = ^{cbus.size, cbus.addr[1:0], cbus.addr[31:AW+2]};

   assign cur_idx = burst_q ? (base_idx_q + AW'(beat_cnt_q)) : base_idx_q;
   assign in_beat = (state_q == S_BEAT);

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      base_idx_d = base_idx_q;
      len_d      = len_q;
      burst_d    = burst_q;
      beat_cnt_d = beat_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      gap_cnt_d  = gap_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cbus.valid) begin
               is_write_d = cbus.is_write;
               base_idx_d = cbus.addr[AW+1:2];
               len_d      = cbus.len;
               burst_d    = cbus.burst;
               beat_cnt_d = '0;
               if (LATENCY == 0) begin
                  state_d = S_BEAT;
               end else begin
                  state_d   = S_WAIT;
                  lat_cnt_d = LW'(LATENCY);
               end
            end
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q - LW'(1);
            if (!cbus.valid) begin
               state_d = S_IDLE;
            end else if (lat_cnt_q == LW'(1)) begin
               state_d = S_BEAT;
            end
         end
         S_BEAT: begin
            // An initiator dropping valid mid-request abandons the rest of it.
            if (!cbus.valid || (beat_cnt_q == len_q)) begin
               state_d = S_IDLE;
            end else begin
               beat_cnt_d = beat_cnt_q + 4'd1;
               if (BEAT_GAP > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = GW'(BEAT_GAP);
               end
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (!cbus.valid) begin
               state_d = S_IDLE;
            end else if (gap_cnt_q == GW'(1)) begin
               state_d = S_BEAT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_rd_word = mem_q[cur_idx];
      mem_wr_en   = in_beat && is_write_q && cbus.valid;
      mem_wr_data = mem_rd_word;
      for (int i = 0; i < 4; i++) begin
         if (cbus.strobe[i]) begin
            mem_wr_data[8*i +: 8] = cbus.wdata[8*i +: 8];
         end
      end
   end

   assign cbus.ready = in_beat;
   assign cbus.last  = in_beat && (beat_cnt_q == len_q);
   assign cbus.rdata = (in_beat && !is_write_q) ? mem_rd_word : 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         is_write_q <= 1'b0;
         base_idx_q <= '0;
         len_q      <= '0;
         burst_q    <= 1'b0;
         beat_cnt_q <= '0;
         lat_cnt_q  <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         base_idx_q <= base_idx_d;
         len_q      <= len_d;
         burst_q    <= burst_d;
         beat_cnt_q <= beat_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr_en) begin
         mem_q[cur_idx] <= mem_wr_data;
      end
   end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: three instances cover default
// timing, zero latency with beat gaps, and a 16-word aliasing array.
module tb_cbus_mem_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        valid = 1'b0;
   logic        is_write = 1'b0;
   logic [2:0]  size = 3'd2;
   logic [31:0] addr = '0;
   logic [3:0]  strobe = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  len = '0;
   logic        burst = 1'b1;
   int          sel = 0;

   logic        o_ready, o_last;
   logic [31:0] o_rdata;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] wbuf [16];
   logic [31:0] rbuf [16];
   logic [63:0] rdy_tr, last_tr;

   cbus_mem_responder_if if_a ();
   cbus_mem_responder_if if_b ();
   cbus_mem_responder_if if_c ();

   assign if_a.valid = valid & (sel == 0);
   assign if_b.valid = valid & (sel == 1);
   assign if_c.valid = valid & (sel == 2);
   assign if_a.is_write = is_write; assign if_b.is_write = is_write; assign if_c.is_write = is_write;
   assign if_a.size = size;         assign if_b.size = size;         assign if_c.size = size;
   assign if_a.addr = addr;         assign if_b.addr = addr;         assign if_c.addr = addr;
   assign if_a.strobe = strobe;     assign if_b.strobe = strobe;     assign if_c.strobe = strobe;
   assign if_a.wdata = wdata;       assign if_b.wdata = wdata;       assign if_c.wdata = wdata;
   assign if_a.len = len;           assign if_b.len = len;           assign if_c.len = len;
   assign if_a.burst = burst;       assign if_b.burst = burst;       assign if_c.burst = burst;

   cbus_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2), .BEAT_GAP(0)) dut_a (
      .clk(clk), .reset(reset), .cbus(if_a));
   cbus_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(0), .BEAT_GAP(1)) dut_b (
      .clk(clk), .reset(reset), .cbus(if_b));
   cbus_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BEAT_GAP(0)) dut_c (
      .clk(clk), .reset(reset), .cbus(if_c));

   always_comb begin
      o_ready = 1'b0;
      o_last  = 1'b0;
      o_rdata = '0;
      case (sel)
         0: begin o_ready = if_a.ready; o_last = if_a.last; o_rdata = if_a.rdata; end
         1: begin o_ready = if_b.ready; o_last = if_b.last; o_rdata = if_b.rdata; end
         2: begin o_ready = if_c.ready; o_last = if_c.last; o_rdata = if_c.rdata; end
         default: ;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Starts just after a rising edge; cycle index 0 is the acceptance cycle.
   // rst_beat >= 0 asserts reset while that beat is being presented.
   task automatic run_txn(input int s, input logic wr, input logic [31:0] a,
                          input logic [3:0] l, input logic incr,
                          input logic [3:0] strb, input int rst_beat);
      int   k;
      int   nb;
      logic done;
      rdy_tr = '0; last_tr = '0; k = 0; nb = 0; done = 1'b0;
      sel = s; is_write = wr; addr = a; len = l; burst = incr; strobe = strb;
      wdata = wbuf[0]; valid = 1'b1;
      while (!done && k < 60) begin
         @(negedge clk);
         if (o_ready) begin
            rdy_tr[k] = 1'b1;
            if (o_last) last_tr[k] = 1'b1;
            if (nb < 16) rbuf[nb] = o_rdata;
            if (nb == rst_beat) begin
               reset = 1'b1;
               #1;
               check_eq("reset_mid_burst_outputs", {30'd0, o_ready, o_last, o_rdata}, 64'd0);
               done = 1'b1;
            end else if (o_last) begin
               done = 1'b1;
            end
            nb++;
         end
         k++;
         @(posedge clk);
         #1;
         if (nb < 16) wdata = wbuf[nb];
      end
      valid = 1'b0;
      check_eq("txn_completed", {63'd0, done}, 64'd1);
      if (reset) begin
         @(posedge clk);
         #1;
         reset = 1'b0;
      end
   endtask

   task automatic single(input int s, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] strb);
      wbuf[0] = d;
      run_txn(s, wr, a, 4'd0, 1'b1, strb, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_eq($sformatf("reset_outputs_%0d", s), {30'd0, o_ready, o_last, o_rdata}, 64'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single write then read, LATENCY=2: beat in cycle 3 after acceptance.
      single(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
      check_eq("single_wr_ready_trace", rdy_tr, 64'h8);
      single(0, 1'b0, 32'h40, 32'h0, 4'h0);
      check_eq("single_rd_ready_trace", rdy_tr, 64'h8);
      check_eq("single_rd_last_trace", last_tr, 64'h8);
      check_eq("single_rd_data", {32'd0, rbuf[0]}, 64'hDEADBEEF);

      // Byte strobes.
      single(0, 1'b1, 32'h14, 32'h11223344, 4'hF);
      single(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101);
      single(0, 1'b0, 32'h14, 32'h0, 4'h0);
      check_eq("strobe_0101", {32'd0, rbuf[0]}, 64'h11BB33DD);
      single(0, 1'b1, 32'h14, 32'h55667788, 4'b1010);
      single(0, 1'b0, 32'h14, 32'h0, 4'h0);
      check_eq("strobe_1010", {32'd0, rbuf[0]}, 64'h55BB77DD);

      // 16-beat INCR burst, back-to-back beats.
      for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
      run_txn(0, 1'b1, 32'h100, 4'd15, 1'b1, 4'hF, -1);
      check_eq("incr16_wr_ready_trace", rdy_tr, 64'h7FFF8);
      run_txn(0, 1'b0, 32'h100, 4'd15, 1'b1, 4'h0, -1);
      check_eq("incr16_rd_ready_trace", rdy_tr, 64'h7FFF8);
      check_eq("incr16_rd_last_trace", last_tr, 64'h40000);
      for (int i = 0; i < 16; i++)
         check_eq($sformatf("incr16_rd_data_%0d", i), {32'd0, rbuf[i]}, 64'hC0DE0000 + 64'(i));

      // FIXED burst with one gap cycle between beats, LATENCY=0.
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      run_txn(1, 1'b1, 32'h8, 4'd3, 1'b0, 4'hF, -1);
      check_eq("fixed_gap_ready_trace", rdy_tr, 64'hAA);
      check_eq("fixed_gap_last_trace", last_tr, 64'h80);
      single(1, 1'b0, 32'h8, 32'h0, 4'h0);
      check_eq("lat0_rd_ready_trace", rdy_tr, 64'h2);
      check_eq("fixed_final_word", {32'd0, rbuf[0]}, 64'h4);

      // Wrap-around on a 16-word array, LATENCY=1.
      single(2, 1'b1, 32'h3C, 32'hF00D000F, 4'hF);
      check_eq("lat1_wr_ready_trace", rdy_tr, 64'h4);
      single(2, 1'b1, 32'h00, 32'hF00D0000, 4'hF);
      single(2, 1'b1, 32'h04, 32'hF00D0001, 4'hF);
      single(2, 1'b1, 32'h08, 32'hF00D0002, 4'hF);
      run_txn(2, 1'b0, 32'h3C, 4'd3, 1'b1, 4'h0, -1);
      check_eq("wrap_rd_ready_trace", rdy_tr, 64'h3C);
      check_eq("wrap_rd_0", {32'd0, rbuf[0]}, 64'hF00D000F);
      check_eq("wrap_rd_1", {32'd0, rbuf[1]}, 64'hF00D0000);
      check_eq("wrap_rd_2", {32'd0, rbuf[2]}, 64'hF00D0001);
      check_eq("wrap_rd_3", {32'd0, rbuf[3]}, 64'hF00D0002);
      single(2, 1'b0, 32'h44, 32'h0, 4'h0);
      check_eq("alias_rd", {32'd0, rbuf[0]}, 64'hF00D0001);

      // valid dropped during latency: no beat may follow.
      sel = 0; is_write = 1'b0; addr = 32'h40; len = 4'd3; burst = 1'b1; strobe = '0;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | o_ready;
      end
      check_eq("abort_no_beat", {63'd0, seen}, 64'd0);
      @(posedge clk);
      #1;
      single(0, 1'b0, 32'h40, 32'h0, 4'h0);
      check_eq("after_abort_rd", {32'd0, rbuf[0]}, 64'hDEADBEEF);

      // Reset during beat 2 of an 8-beat write.
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h0;
      run_txn(0, 1'b1, 32'h200, 4'd7, 1'b1, 4'hF, -1);
      for (int i = 0; i < 16; i++) wbuf[i] = 32'hB0 + 32'(i);
      run_txn(0, 1'b1, 32'h200, 4'd7, 1'b1, 4'hF, 2);
      run_txn(0, 1'b0, 32'h200, 4'd7, 1'b1, 4'h0, -1);
      check_eq("post_reset_ready_trace", rdy_tr, 64'h7F8);
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("post_reset_word_%0d", i), {32'd0, rbuf[i]},
                  (i < 2) ? 64'hB0 + 64'(i) : 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
